// File: rtl/demux1to2_pipe.sv
// -----------------------------------------------------------------------------
// demux1to2_pipe
//   Registered 1-to-2 stream demultiplexer. Each input beat carries a channel
//   select and is steered into a one-entry holding register on out0 or out1.
//   Each output channel has independent valid/ready flow control, so a stalled
//   consumer only back-pressures beats addressed to its own channel.
//
//   Optional feature macro: DEMUX_CNT_EN
//     When defined, per-channel delivered-beat counters cnt0/cnt1 (CNT_W bits,
//     wrapping) are added to the port list.
// -----------------------------------------------------------------------------
module demux1to2_pipe #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [W-1:0]     out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    // Elaboration-time sanity check on parameters.
    if (W < 1 || CNT_W < 1) begin : g_bad_params
        $error("demux1to2_pipe: W and CNT_W must be >= 1");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_t;

    chan_state_t r_st0, r_st1;
    chan_state_t w_st0_nxt, w_st1_nxt;
    logic [W-1:0] r_data0, r_data1;

    logic w_drain0, w_drain1;
    logic w_space0, w_space1;
    logic w_accept;
    logic w_acc0, w_acc1;
    logic w_load0, w_load1;

    assign out0_valid = (r_st0 == ST_FULL);
    assign out1_valid = (r_st1 == ST_FULL);
    assign out0_data  = r_data0;
    assign out1_data  = r_data1;

    // Per-channel drain/space qualifiers and the combinational input handshake.
    always_comb begin
        w_drain0 = out0_valid & out0_ready;
        w_drain1 = out1_valid & out1_ready;
        w_space0 = ~out0_valid | out0_ready;
        w_space1 = ~out1_valid | out1_ready;
        in_ready = in_sel ? w_space1 : w_space0;
        w_accept = in_valid & in_ready;
        w_acc0   = w_accept & ~in_sel;
        w_acc1   = w_accept &  in_sel;
    end

    // Channel 0 next-state and data-load decode.
    always_comb begin
        w_st0_nxt = r_st0;
        w_load0   = 1'b0;
        unique case (r_st0)
            ST_EMPTY: begin
                if (w_acc0) begin
                    w_st0_nxt = ST_FULL;
                    w_load0   = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_drain0) begin
                    if (w_acc0) begin
                        w_st0_nxt = ST_FULL;
                        w_load0   = 1'b1;
                    end else begin
                        w_st0_nxt = ST_EMPTY;
                    end
                end
            end
            default: w_st0_nxt = ST_EMPTY;
        endcase
    end

    // Channel 1 next-state and data-load decode.
    always_comb begin
        w_st1_nxt = r_st1;
        w_load1   = 1'b0;
        unique case (r_st1)
            ST_EMPTY: begin
                if (w_acc1) begin
                    w_st1_nxt = ST_FULL;
                    w_load1   = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_drain1) begin
                    if (w_acc1) begin
                        w_st1_nxt = ST_FULL;
                        w_load1   = 1'b1;
                    end else begin
                        w_st1_nxt = ST_EMPTY;
                    end
                end
            end
            default: w_st1_nxt = ST_EMPTY;
        endcase
    end

    // Channel state registers; reset discards any held beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st0 <= ST_EMPTY;
            r_st1 <= ST_EMPTY;
        end else begin
            r_st0 <= w_st0_nxt;
            r_st1 <= w_st1_nxt;
        end
    end

    // Holding registers load only on accept; otherwise they keep the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            if (w_load0) begin
                r_data0 <= in_data;
            end
            if (w_load1) begin
                r_data1 <= in_data;
            end
        end
    end

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_cnt0, r_cnt1;

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;

    // Delivered-beat counters, one step per drain, silently wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_drain0) begin
                r_cnt0 <= r_cnt0 + 1'b1;
            end
            if (w_drain1) begin
                r_cnt1 <= r_cnt1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux1to2_pipe.sv
// -----------------------------------------------------------------------------
// tb_demux1to2_pipe
//   Directed testbench for demux1to2_pipe. A per-channel queue model predicts
//   outputs every cycle; literal expectations pin the documented scenarios.
//   Define DEMUX_CNT_EN to also exercise the counters (built with CNT_W=4).
// -----------------------------------------------------------------------------
module tb_demux1to2_pipe;

`ifdef DEMUX_CNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX_CNT_EN
    logic [TB_CNT_W-1:0] cnt0;
    logic [TB_CNT_W-1:0] cnt1;
`endif

    int checks   = 0;
    int failures = 0;

    demux1to2_pipe #(
        .W    (8),
        .CNT_W(TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data (out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is a one-entry FIFO plus its last-written value.
    byte unsigned mq0[$];
    byte unsigned mq1[$];
    logic [7:0]   ml0 = 8'h00;
    logic [7:0]   ml1 = 8'h00;
    int unsigned  mc0 = 0;
    int unsigned  mc1 = 0;

    function automatic logic model_ready();
        if (in_sel) return (mq1.size() == 0) || (out1_ready == 1'b1);
        else        return (mq0.size() == 0) || (out0_ready == 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic acc;
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            ml0 = 8'h00;
            ml1 = 8'h00;
            mc0 = 0;
            mc1 = 0;
        end else begin
            acc = (in_valid == 1'b1) && model_ready();
            if (mq0.size() != 0 && out0_ready) begin
                void'(mq0.pop_front());
                mc0++;
            end
            if (mq1.size() != 0 && out1_ready) begin
                void'(mq1.pop_front());
                mc1++;
            end
            if (acc) begin
                if (in_sel) begin
                    mq1.push_back(in_data);
                    ml1 = in_data;
                end else begin
                    mq0.push_back(in_data);
                    ml0 = in_data;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready",   {31'd0, in_ready},   {31'd0, model_ready()});
        chk("out0_valid", {31'd0, out0_valid}, {31'd0, (mq0.size() != 0)});
        chk("out1_valid", {31'd0, out1_valid}, {31'd0, (mq1.size() != 0)});
        chk("out0_data",  {24'd0, out0_data},  {24'd0, ml0});
        chk("out1_data",  {24'd0, out1_data},  {24'd0, ml1});
`ifdef DEMUX_CNT_EN
        chk("cnt0", {{(32-TB_CNT_W){1'b0}}, cnt0}, mc0 & ((32'd1 << TB_CNT_W) - 1));
        chk("cnt1", {{(32-TB_CNT_W){1'b0}}, cnt1}, mc1 & ((32'd1 << TB_CNT_W) - 1));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        step();
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        chk("rst_out0_data",  {24'd0, out0_data},  32'h00);
        chk("rst_out1_data",  {24'd0, out1_data},  32'h00);
        rst_n = 1'b1;
        step();

        // Single beat to channel 0.
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11;
        step();
        in_valid = 1'b0;
        chk("t2_out0_valid", {31'd0, out0_valid}, 32'd1);
        chk("t2_out0_data",  {24'd0, out0_data},  32'h11);
        chk("t2_out1_valid", {31'd0, out1_valid}, 32'd0);
        step();

        // Alternating selects, one clock latency each.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_sel   = logic'(i & 1);
            in_data  = 8'(i + 1);
            step();
            if ((i & 1) == 0) begin
                chk("t3_out0_valid", {31'd0, out0_valid}, 32'd1);
                chk("t3_out0_data",  {24'd0, out0_data},  32'(i + 1));
            end else begin
                chk("t3_out1_valid", {31'd0, out1_valid}, 32'd1);
                chk("t3_out1_data",  {24'd0, out1_data},  32'(i + 1));
            end
        end
        in_valid = 1'b0;
        step();

        // Stalled channel 1 blocks only its own beats.
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h22;
        step();
        in_data = 8'h33;
        #1;
        chk("t4_in_ready_blocked", {31'd0, in_ready}, 32'd0);
        step();
        chk("t4_out1_valid_held", {31'd0, out1_valid}, 32'd1);
        chk("t4_out1_data_held",  {24'd0, out1_data},  32'h22);
        in_sel = 1'b0; in_data = 8'h44;
        #1;
        chk("t4_in_ready_other", {31'd0, in_ready}, 32'd1);
        step();
        chk("t4_out0_data",      {24'd0, out0_data}, 32'h44);
        chk("t4_out1_data_still",{24'd0, out1_data}, 32'h22);
        in_valid = 1'b0;
        out1_ready = 1'b1;
        step();

        // Back-to-back replacement on a draining full channel.
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
        step();
        chk("t5_out0_data_55", {24'd0, out0_data}, 32'h55);
        out0_ready = 1'b1;
        in_data = 8'h66;
        #1;
        chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("t5_out0_valid", {31'd0, out0_valid}, 32'd1);
        chk("t5_out0_data",  {24'd0, out0_data},  32'h66);
        in_valid = 1'b0;
        step();

        // Mixed pattern of traffic and back-pressure, checked by the model.
        for (int i = 0; i < 24; i++) begin
            in_valid   = ((i % 3) != 2);
            in_sel     = logic'(((i >> 1) ^ i) & 1);
            in_data    = 8'(8'h80 + i);
            out0_ready = ((i % 4) != 0);
            out1_ready = ((i % 5) > 1);
            step();
        end
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        step();
        step();

`ifdef DEMUX_CNT_EN
        // Counter wrap: 17 beats on channel 1 with a 4-bit counter.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_sel = 1'b1; in_data = 8'(i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("t6_cnt1_wrapped", {28'd0, cnt1}, 32'd1);
        chk("t6_cnt0_zero",    {28'd0, cnt0}, 32'd0);
        step();
`endif

        // Asynchronous reset while channel 0 holds 0xA5.
        out0_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("t1_out0_full", {24'd0, out0_data}, 32'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_valid", {31'd0, out0_valid}, 32'd0);
        chk("t1_async_data",  {24'd0, out0_data},  32'h00);
        step();
        rst_n = 1'b1;
        out0_ready = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
